// File: rtl/fetch_unit_if.sv
// Fetch-to-environment bus: branch redirect, instruction memory port, decode handshake
// and performance counters.
// master = fetch_unit side, slave = memory/decode/execute side.
interface fetch_unit_if;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fetch_done;
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;

   modport master (
      input  branch_taken, branch_addr, imem_rdata, id_ready,
      output imem_addr, id_valid, id_pc, id_instr, fetch_done, perf_fetch, perf_stall
   );

   modport slave (
      output branch_taken, branch_addr, imem_rdata, id_ready,
      input  imem_addr, id_valid, id_pc, id_instr, fetch_done, perf_fetch, perf_stall
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory and
// queues {PC+4, instr} pairs in a DEPTH-entry FIFO towards decode (valid/ready).
// Ports: clk, rst (sync, active-high), bus (fetch_unit_if.master).
// Latency: one edge from fetch to id_*; a taken branch flushes the FIFO, and the first
// post-branch entry appears two edges after the redirect.
// Backpressure: a full FIFO with no dequeue holds the PC; id_* are registered and never
// depend combinationally on id_ready.
// Optional: define FETCH_PERF_EN to build the perf_fetch/perf_stall counters.
module fetch_unit #(
   parameter int DEPTH      = 4,
   parameter int IMEM_BYTES = 72
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);
   localparam int          AW         = $clog2(DEPTH);
   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_next;
   logic [AW:0]   count;
   logic [AW:0]   count_after_deq;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;
   logic          in_range;
   logic          full;
   logic          valid;
   logic          deq;
   logic          enq;
   logic          unused_ok;

   assign pc_plus4        = pc + 32'd4;
   assign in_range        = (pc < IMEM_LIMIT);
   assign full            = (count == FULL_CNT);
   assign valid           = (count != '0);
   assign deq             = valid & bus.id_ready;
   // A simultaneous dequeue frees the slot the new entry needs, so full does not block.
   assign enq             = !bus.branch_taken & in_range & (!full | deq);
   assign count_after_deq = count - (AW+1)'(deq);
   assign rd_ptr_next     = rd_ptr + AW'(deq);

   // Branch targets are word aligned; the low address bits are ignored.
   assign unused_ok = ^bus.branch_addr[1:0];

   // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_pc[wr_ptr]    <= pc_plus4;
         mem_instr[wr_ptr] <= bus.imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_pc    <= '0;
         head_instr <= '0;
      end else if (bus.branch_taken) begin
         // Redirect overrides everything: flush, no enqueue or dequeue this cycle.
         pc     <= {bus.branch_addr[31:2], 2'b00};
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + AW'(1);
            pc     <= pc_plus4;
         end
         rd_ptr <= rd_ptr_next;
         count  <= count_after_deq + (AW+1)'(enq);
         // Preload the output register with whatever will be the head after this edge.
         // If the FIFO drains to empty the last head value is simply held.
         if (count_after_deq != '0) begin
            head_pc    <= mem_pc[rd_ptr_next];
            head_instr <= mem_instr[rd_ptr_next];
         end else if (enq) begin
            head_pc    <= pc_plus4;
            head_instr <= bus.imem_rdata;
         end
      end
   end

   assign bus.imem_addr  = pc;
   assign bus.id_valid   = valid;
   assign bus.id_pc      = head_pc;
   assign bus.id_instr   = head_instr;
   assign bus.fetch_done = !in_range & !bus.branch_taken;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch <= '0;
         perf_stall <= '0;
      end else begin
         if (enq)
            perf_fetch <= perf_fetch + 32'd1;
         if (full & !deq & !bus.branch_taken & in_range)
            perf_stall <= perf_stall + 32'd1;
      end
   end

   assign bus.perf_fetch = perf_fetch;
   assign bus.perf_stall = perf_stall;
`else
   assign bus.perf_fetch = 32'd0;
   assign bus.perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit (DEPTH=4, IMEM_BYTES=72): cycle-by-cycle vector table for
// reset, streaming, backpressure, full-steady-state and branch flush, then hand-written
// sequences for end-of-memory drain/restart and reset during a full FIFO with a branch.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   fetch_unit_if bus ();

   fetch_unit #(.DEPTH(4), .IMEM_BYTES(72)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory model: a distinct word per address.
   function automatic logic [31:0] w(input logic [31:0] a);
      return {16'hE3A0, a[15:0]};
   endfunction

   always_comb bus.imem_rdata = w(bus.imem_addr);

   typedef struct {
      logic        rst;
      logic        br;
      logic [31:0] baddr;
      logic        rdy;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        done;
      logic [31:0] pf;
      logic [31:0] ps;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(input logic r, input logic b, input logic [31:0] ba,
                               input logic rd, input logic [31:0] a, input logic v,
                               input logic [31:0] p, input logic [31:0] ins,
                               input logic d, input logic [31:0] pf, input logic [31:0] ps);
      vec_t t;
      t.rst = r; t.br = b; t.baddr = ba; t.rdy = rd;
      t.addr = a; t.vld = v; t.pc = p; t.instr = ins; t.done = d;
      t.pf = PERF ? pf : 32'd0;
      t.ps = PERF ? ps : 32'd0;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_pc;

      // rst br baddr rdy | addr vld id_pc id_instr done perf_fetch perf_stall
      vecs[0]  = mk(1, 0, 0,     1, 0,     0, 0,     0,        0, 0, 0);
      vecs[1]  = mk(1, 0, 0,     1, 0,     0, 0,     0,        0, 0, 0);
      vecs[2]  = mk(0, 0, 0,     1, 4,     1, 4,     w(0),     0, 1, 0);
      vecs[3]  = mk(0, 0, 0,     1, 8,     1, 8,     w(4),     0, 2, 0);
      vecs[4]  = mk(0, 0, 0,     1, 12,    1, 12,    w(8),     0, 3, 0);
      vecs[5]  = mk(1, 0, 0,     0, 0,     0, 0,     0,        0, 0, 0);
      vecs[6]  = mk(0, 0, 0,     0, 4,     1, 4,     w(0),     0, 1, 0);
      vecs[7]  = mk(0, 0, 0,     0, 8,     1, 4,     w(0),     0, 2, 0);
      vecs[8]  = mk(0, 0, 0,     0, 12,    1, 4,     w(0),     0, 3, 0);
      vecs[9]  = mk(0, 0, 0,     0, 16,    1, 4,     w(0),     0, 4, 0);
      for (int i = 10; i <= 15; i++)
         vecs[i] = mk(0, 0, 0,   0, 16,    1, 4,     w(0),     0, 4, 32'(i - 9));
      vecs[16] = mk(0, 0, 0,     1, 20,    1, 8,     w(4),     0, 5, 6);
      vecs[17] = mk(0, 0, 0,     1, 24,    1, 12,    w(8),     0, 6, 6);
      vecs[18] = mk(0, 0, 0,     1, 28,    1, 16,    w(12),    0, 7, 6);
      vecs[19] = mk(0, 0, 0,     1, 32,    1, 20,    w(16),    0, 8, 6);
      vecs[20] = mk(0, 0, 0,     1, 36,    1, 24,    w(20),    0, 9, 6);
      vecs[21] = mk(0, 1, 32'h10, 1, 32'h10, 0, 0,    0,        0, 9, 6);
      vecs[22] = mk(0, 0, 0,     0, 32'h14, 1, 32'h14, w(32'h10), 0, 10, 6);
      vecs[23] = mk(0, 0, 0,     0, 32'h18, 1, 32'h14, w(32'h10), 0, 11, 6);
      vecs[24] = mk(0, 0, 0,     0, 32'h1C, 1, 32'h14, w(32'h10), 0, 12, 6);
      vecs[25] = mk(0, 1, 32'h2B, 1, 32'h28, 0, 0,    0,        0, 12, 6);
      vecs[26] = mk(0, 0, 0,     1, 32'h2C, 1, 32'h2C, w(32'h28), 0, 13, 6);

      rst = 1'b1;
      bus.branch_taken = 1'b0;
      bus.branch_addr  = '0;
      bus.id_ready     = 1'b0;

      for (int i = 0; i < 27; i++) begin
         rst              = vecs[i].rst;
         bus.branch_taken = vecs[i].br;
         bus.branch_addr  = vecs[i].baddr;
         bus.id_ready     = vecs[i].rdy;
         step();
         check($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].addr);
         check($sformatf("v%0d id_valid", i), 32'(bus.id_valid), 32'(vecs[i].vld));
         check($sformatf("v%0d fetch_done", i), 32'(bus.fetch_done), 32'(vecs[i].done));
         check($sformatf("v%0d perf_fetch", i), bus.perf_fetch, vecs[i].pf);
         check($sformatf("v%0d perf_stall", i), bus.perf_stall, vecs[i].ps);
         // Head contents are only meaningful when valid, or right after reset.
         if (vecs[i].vld || vecs[i].rst) begin
            check($sformatf("v%0d id_pc", i), bus.id_pc, vecs[i].pc);
            check($sformatf("v%0d id_instr", i), bus.id_instr, vecs[i].instr);
         end
      end

      // Free-run to the end of memory with decode always ready.
      exp_pc = 32'h2C;
      for (int c = 0; c < 40 && bus.imem_addr != 32'd72; c++) begin
         step();
         exp_pc += 32'd4;
         check("run id_valid", 32'(bus.id_valid), 32'd1);
         check("run id_pc", bus.id_pc, exp_pc);
         check("run id_instr", bus.id_instr, w(exp_pc - 32'd4));
      end
      check("end imem_addr", bus.imem_addr, 32'd72);
      check("end id_pc", bus.id_pc, 32'd72);
      check("end fetch_done", 32'(bus.fetch_done), 32'd1);
      step();
      check("drain id_valid", 32'(bus.id_valid), 32'd0);
      check("drain imem_addr", bus.imem_addr, 32'd72);
      check("drain fetch_done", 32'(bus.fetch_done), 32'd1);
      bus.id_ready = 1'b0;
      repeat (3) step();
      check("hold imem_addr", bus.imem_addr, 32'd72);
      check("hold id_valid", 32'(bus.id_valid), 32'd0);
      bus.branch_taken = 1'b1;
      bus.branch_addr  = 32'd0;
      #1;
      check("pending fetch_done", 32'(bus.fetch_done), 32'd0);
      step();
      check("restart imem_addr", bus.imem_addr, 32'd0);
      check("restart fetch_done", 32'(bus.fetch_done), 32'd0);
      bus.branch_taken = 1'b0;
      step();
      check("restart id_valid", 32'(bus.id_valid), 32'd1);
      check("restart id_pc", bus.id_pc, 32'd4);
      check("restart id_instr", bus.id_instr, w(32'd0));

      // Fill the FIFO, then reset together with a branch: reset must win.
      repeat (3) step();
      check("fill imem_addr", bus.imem_addr, 32'd16);
      rst              = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_addr  = 32'h40;
      bus.id_ready     = 1'b1;
      step();
      check("rst imem_addr", bus.imem_addr, 32'd0);
      check("rst id_valid", 32'(bus.id_valid), 32'd0);
      check("rst id_pc", bus.id_pc, 32'd0);
      check("rst id_instr", bus.id_instr, 32'd0);
      check("rst perf_fetch", bus.perf_fetch, 32'd0);
      check("rst perf_stall", bus.perf_stall, 32'd0);
      rst              = 1'b0;
      bus.branch_taken = 1'b0;
      step();
      check("post-rst imem_addr", bus.imem_addr, 32'd4);
      check("post-rst id_pc", bus.id_pc, 32'd4);
      check("post-rst id_valid", 32'(bus.id_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
